// File: rtl/gmii_tx_monitor.sv
// Passive GMII/MII transmit-side frame checker: delineates frames by preamble/SFD and
// reports FCS, length, IFG, tx_er and nibble-alignment status plus good/bad frame counters.
module gmii_tx_monitor #(
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int MAX_FRAME_LENGTH = 1518,
  parameter int MIN_IFG          = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_enable,
  input  logic        mii_select,
  input  logic [7:0]  gmii_txd,
  input  logic        gmii_tx_en,
  input  logic        gmii_tx_er,
  output logic        status_valid,
  output logic [15:0] status_len,
  output logic        status_good,
  output logic        status_err_preamble,
  output logic        status_err_fcs,
  output logic        status_err_runt,
  output logic        status_err_oversize,
  output logic        status_err_tx_er,
  output logic        status_err_ifg,
  output logic        status_err_align,
  output logic [31:0] good_count,
  output logic [31:0] bad_count
);

  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;
  localparam logic [15:0] MIN_LEN      = 16'(MIN_FRAME_LENGTH);
  localparam logic [15:0] MAX_LEN      = 16'(MAX_FRAME_LENGTH);
  localparam logic [7:0]  MIN_GAP      = 8'(MIN_IFG);
  localparam logic [7:0]  SYM_PREAMBLE = 8'h55;
  localparam logic [7:0]  SYM_SFD      = 8'hD5;

  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_ERR} state_t;

  state_t      state_reg, state_next, byte_state;
  logic [2:0]  pre_cnt_reg, pre_cnt_next, cur_pre;
  logic [15:0] len_reg, len_next, len_inc;
  logic [31:0] crc_reg, crc_next;
  logic        nib_phase_reg, nib_phase_next, cur_phase;
  logic [3:0]  nib_low_reg, nib_low_next;
  logic        tx_en_d_reg, tx_en_d_next;
  logic        tx_er_seen_reg, tx_er_seen_next;
  logic        ifg_err_reg, ifg_err_next;
  logic [7:0]  gap_cnt_reg, gap_cnt_next, gap_base;
  logic        gap_half_reg, gap_half_next, gap_half_base;

  logic        start, frame_end, in_frame, byte_valid;
  logic [7:0]  byte_data;

  logic        end_err_preamble, end_err_fcs, end_err_runt, end_err_oversize, end_good;

  logic        status_valid_reg, status_good_reg;
  logic [15:0] status_len_reg;
  logic        status_err_preamble_reg, status_err_fcs_reg, status_err_runt_reg;
  logic        status_err_oversize_reg, status_err_tx_er_reg, status_err_ifg_reg;
  logic        status_err_align_reg;
  logic [31:0] good_count_reg, bad_count_reg;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] crc;
    crc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc[0] ^ data[i]) crc = (crc >> 1) ^ CRC_POLY;
      else                  crc = crc >> 1;
    end
    return crc;
  endfunction

  // tx_en_d_reg resets high so a frame already in flight at reset release is ignored.
  assign start      = clk_enable && (state_reg == ST_IDLE) && gmii_tx_en && !tx_en_d_reg;
  assign frame_end  = clk_enable && (state_reg != ST_IDLE) && !gmii_tx_en;
  assign in_frame   = clk_enable && gmii_tx_en && ((state_reg != ST_IDLE) || start);
  assign cur_phase  = start ? 1'b0 : nib_phase_reg;
  assign cur_pre    = start ? 3'd0 : pre_cnt_reg;
  assign byte_valid = in_frame && (!mii_select || cur_phase);
  assign byte_data  = mii_select ? {gmii_txd[3:0], nib_low_reg} : gmii_txd;
  assign len_inc    = (len_reg == 16'hFFFF) ? len_reg : len_reg + 16'd1;
  assign tx_en_d_next = clk_enable ? gmii_tx_en : tx_en_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    pre_cnt_next    = pre_cnt_reg;
    len_next        = len_reg;
    crc_next        = crc_reg;
    nib_phase_next  = nib_phase_reg;
    nib_low_next    = nib_low_reg;
    tx_er_seen_next = tx_er_seen_reg;
    ifg_err_next    = ifg_err_reg;
    byte_state      = start ? ST_PREAMBLE : state_reg;

    if (start) begin
      state_next      = ST_PREAMBLE;
      pre_cnt_next    = 3'd0;
      len_next        = 16'd0;
      crc_next        = 32'hFFFFFFFF;
      tx_er_seen_next = gmii_tx_er;
      ifg_err_next    = (gap_cnt_reg < MIN_GAP);
    end else if (in_frame) begin
      tx_er_seen_next = tx_er_seen_reg | gmii_tx_er;
    end

    if (in_frame && mii_select) begin
      nib_phase_next = ~cur_phase;
      if (!cur_phase) nib_low_next = gmii_txd[3:0];
    end

    if (byte_valid) begin
      case (byte_state)
        ST_PREAMBLE: begin
          if (byte_data == SYM_PREAMBLE && cur_pre != 3'd7) begin
            pre_cnt_next = cur_pre + 3'd1;
          end else if (byte_data == SYM_SFD && cur_pre != 3'd0) begin
            state_next = ST_DATA;
            crc_next   = 32'hFFFFFFFF;
          end else begin
            state_next = ST_ERR;
          end
        end
        ST_DATA: begin
          crc_next = crc32_byte(crc_reg, byte_data);
          len_next = len_inc;
        end
        ST_ERR:  len_next = len_inc;
        default: len_next = len_reg;
      endcase
    end

    // A pending low nibble at frame end is discarded; the end-of-frame status flags it.
    if (frame_end) begin
      state_next     = ST_IDLE;
      nib_phase_next = 1'b0;
    end
  end

  // Gap counts idle byte-times; in MII two enabled idle cycles make one byte-time.
  assign gap_base      = frame_end ? 8'd0 : gap_cnt_reg;
  assign gap_half_base = frame_end ? 1'b0 : gap_half_reg;

  always_comb begin
    gap_cnt_next  = gap_cnt_reg;
    gap_half_next = gap_half_reg;
    if (clk_enable && !gmii_tx_en) begin
      if (!mii_select || gap_half_base) begin
        gap_cnt_next  = (gap_base == 8'hFF) ? gap_base : gap_base + 8'd1;
        gap_half_next = 1'b0;
      end else begin
        gap_cnt_next  = gap_base;
        gap_half_next = 1'b1;
      end
    end
  end

  // A frame can only end from PREAMBLE, DATA or ERR; anything but DATA is a preamble fault.
  assign end_err_preamble = (state_reg != ST_DATA);
  assign end_err_fcs      = (state_reg == ST_DATA) && (crc_reg != CRC_RESIDUE);
  assign end_err_runt     = (len_reg < MIN_LEN);
  assign end_err_oversize = (len_reg > MAX_LEN);
  assign end_good         = !(end_err_preamble || end_err_fcs || end_err_runt || end_err_oversize ||
                              tx_er_seen_reg || ifg_err_reg || nib_phase_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_reg    <= 3'd0;
      len_reg        <= 16'd0;
      crc_reg        <= 32'hFFFFFFFF;
      nib_phase_reg  <= 1'b0;
      nib_low_reg    <= 4'd0;
      tx_en_d_reg    <= 1'b1;
      tx_er_seen_reg <= 1'b0;
      ifg_err_reg    <= 1'b0;
      gap_cnt_reg    <= 8'hFF;
      gap_half_reg   <= 1'b0;
    end else begin
      pre_cnt_reg    <= pre_cnt_next;
      len_reg        <= len_next;
      crc_reg        <= crc_next;
      nib_phase_reg  <= nib_phase_next;
      nib_low_reg    <= nib_low_next;
      tx_en_d_reg    <= tx_en_d_next;
      tx_er_seen_reg <= tx_er_seen_next;
      ifg_err_reg    <= ifg_err_next;
      gap_cnt_reg    <= gap_cnt_next;
      gap_half_reg   <= gap_half_next;
    end
  end

  // status_valid is rewritten every clk so the pulse lasts one cycle regardless of clk_enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_valid_reg        <= 1'b0;
      status_len_reg          <= 16'd0;
      status_good_reg         <= 1'b0;
      status_err_preamble_reg <= 1'b0;
      status_err_fcs_reg      <= 1'b0;
      status_err_runt_reg     <= 1'b0;
      status_err_oversize_reg <= 1'b0;
      status_err_tx_er_reg    <= 1'b0;
      status_err_ifg_reg      <= 1'b0;
      status_err_align_reg    <= 1'b0;
      good_count_reg          <= 32'd0;
      bad_count_reg           <= 32'd0;
    end else begin
      status_valid_reg <= frame_end;
      if (frame_end) begin
        status_len_reg          <= len_reg;
        status_good_reg         <= end_good;
        status_err_preamble_reg <= end_err_preamble;
        status_err_fcs_reg      <= end_err_fcs;
        status_err_runt_reg     <= end_err_runt;
        status_err_oversize_reg <= end_err_oversize;
        status_err_tx_er_reg    <= tx_er_seen_reg;
        status_err_ifg_reg      <= ifg_err_reg;
        status_err_align_reg    <= nib_phase_reg;
        if (end_good) good_count_reg <= good_count_reg + 32'd1;
        else          bad_count_reg  <= bad_count_reg + 32'd1;
      end
    end
  end

  assign status_valid        = status_valid_reg;
  assign status_len          = status_len_reg;
  assign status_good         = status_good_reg;
  assign status_err_preamble = status_err_preamble_reg;
  assign status_err_fcs      = status_err_fcs_reg;
  assign status_err_runt     = status_err_runt_reg;
  assign status_err_oversize = status_err_oversize_reg;
  assign status_err_tx_er    = status_err_tx_er_reg;
  assign status_err_ifg      = status_err_ifg_reg;
  assign status_err_align    = status_err_align_reg;
  assign good_count          = good_count_reg;
  assign bad_count           = bad_count_reg;

endmodule

// File: tb/tb_gmii_tx_monitor.sv
// Randomized bench for gmii_tx_monitor: frames are built as byte lists and the expected
// status is derived from the frame contents (preamble parse, CRC-32 compare, lengths, gaps).
module tb_gmii_tx_monitor;

  logic        clk = 1'b0;
  logic        rst_n, clk_enable, mii_select;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en, gmii_tx_er;
  logic        status_valid, status_good;
  logic [15:0] status_len;
  logic        status_err_preamble, status_err_fcs, status_err_runt, status_err_oversize;
  logic        status_err_tx_er, status_err_ifg, status_err_align;
  logic [31:0] good_count, bad_count;

  gmii_tx_monitor dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .mii_select(mii_select),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .status_valid(status_valid), .status_len(status_len), .status_good(status_good),
    .status_err_preamble(status_err_preamble), .status_err_fcs(status_err_fcs),
    .status_err_runt(status_err_runt), .status_err_oversize(status_err_oversize),
    .status_err_tx_er(status_err_tx_er), .status_err_ifg(status_err_ifg),
    .status_err_align(status_err_align), .good_count(good_count), .bad_count(bad_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  int exp_good = 0, exp_bad = 0, exp_frames = 0, frame_no = 0;
  bit first_frame = 1'b1;
  bit cur_mii = 1'b0;
  logic [7:0] frm[$];

  always @(negedge clk) if (status_valid) pulse_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One enabled clock; sometimes preceded by disabled cycles carrying junk inputs.
  task automatic step(input logic en, input logic er, input logic [7:0] d);
    if ($urandom_range(0, 7) == 0) begin
      clk_enable = 1'b0;
      gmii_tx_en = 1'($urandom);
      gmii_tx_er = 1'($urandom);
      gmii_txd   = 8'($urandom);
      @(posedge clk); #1;
    end
    clk_enable = 1'b1;
    gmii_tx_en = en;
    gmii_tx_er = er;
    gmii_txd   = d;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] crc_range(input int a, input int b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = a; i < b; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic make_frame(input int n55, input logic [7:0] sfd, input int total_len, input bit flip);
    int          first;
    logic [31:0] fcs;
    logic [7:0]  mask;
    frm.delete();
    repeat (n55) frm.push_back(8'h55);
    frm.push_back(sfd);
    first = frm.size();
    for (int i = 0; i < total_len - 4; i++) frm.push_back(8'($urandom));
    fcs = crc_range(first, frm.size());
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    if (flip) begin
      mask = 8'd1 << $urandom_range(0, 7);
      frm[frm.size() - 1 - int'($urandom_range(0, 3))] ^= mask;
    end
  endtask

  task automatic send_frame(input bit mii, input int gap_in, input int er_idx, input bit trunc,
                            input string name);
    int          gap, k, rx_len;
    bit          pre_ok, e_fcs, e_runt, e_over, e_ifg, e_good, er;
    logic [31:0] fcs_rx;
    logic [7:0]  b;
    gap = gap_in;
    if (mii != cur_mii && gap < 16) gap = 16;

    k = 0;
    while (k < frm.size() && frm[k] == 8'h55) k++;
    pre_ok = (k >= 1) && (k <= 7) && (k < frm.size()) && (frm[k] == 8'hD5);
    rx_len = frm.size() - k - 1 - (trunc ? 1 : 0);
    e_fcs = 1'b0;
    if (pre_ok) begin
      if (rx_len < 4) e_fcs = 1'b1;
      else begin
        fcs_rx = {frm[k+rx_len], frm[k+rx_len-1], frm[k+rx_len-2], frm[k+rx_len-3]};
        e_fcs  = (crc_range(k + 1, k + rx_len - 3) != fcs_rx);
      end
    end
    e_runt = pre_ok && (rx_len < 64);
    e_over = pre_ok && (rx_len > 1518);
    e_ifg  = !first_frame && (gap < 12);
    e_good = pre_ok && !e_fcs && !e_runt && !e_over && !e_ifg && (er_idx < 0) && !trunc;

    mii_select = mii;
    cur_mii    = mii;
    repeat (gap * (mii ? 2 : 1) - 1) step(1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < frm.size(); i++) begin
      er = (i == er_idx);
      b  = frm[i];
      if (!mii) step(1'b1, er, b);
      else begin
        step(1'b1, er, {4'($urandom), b[3:0]});
        if (!(trunc && i == frm.size() - 1)) step(1'b1, 1'b0, {4'($urandom), b[7:4]});
      end
    end
    check_val($sformatf("%s.early_valid", name), {31'd0, status_valid}, 32'd0);
    step(1'b0, 1'b0, 8'($urandom));

    check_val($sformatf("%s.valid", name), {31'd0, status_valid}, 32'd1);
    check_val($sformatf("%s.err_preamble", name), {31'd0, status_err_preamble}, {31'd0, !pre_ok});
    check_val($sformatf("%s.err_fcs", name), {31'd0, status_err_fcs}, {31'd0, e_fcs});
    check_val($sformatf("%s.err_tx_er", name), {31'd0, status_err_tx_er}, {31'd0, er_idx >= 0});
    check_val($sformatf("%s.err_ifg", name), {31'd0, status_err_ifg}, {31'd0, e_ifg});
    check_val($sformatf("%s.err_align", name), {31'd0, status_err_align}, {31'd0, trunc});
    check_val($sformatf("%s.good", name), {31'd0, status_good}, {31'd0, e_good});
    if (pre_ok) begin
      check_val($sformatf("%s.len", name), {16'd0, status_len}, 32'(rx_len));
      check_val($sformatf("%s.err_runt", name), {31'd0, status_err_runt}, {31'd0, e_runt});
      check_val($sformatf("%s.err_oversize", name), {31'd0, status_err_oversize}, {31'd0, e_over});
    end
    if (e_good) exp_good++;
    else        exp_bad++;
    exp_frames++;
    first_frame = 1'b0;
    check_val($sformatf("%s.good_count", name), good_count, 32'(exp_good));
    check_val($sformatf("%s.bad_count", name), bad_count, 32'(exp_bad));
    frame_no++;
    $display("[TB] frame %0d %s mii=%0d gap=%0d len=%0d status_good=%0d exp_good=%0d",
             frame_no, name, mii, gap, status_len, status_good, e_good);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len_tab[4];
    int n55, len, er_idx, pv;
    bit mii, flip, trunc;
    logic [7:0] sfd;

    rst_n = 1'b0; clk_enable = 1'b0; mii_select = 1'b0;
    gmii_tx_en = 1'b0; gmii_tx_er = 1'b0; gmii_txd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset.valid", {31'd0, status_valid}, 32'd0);
    check_val("reset.len", {16'd0, status_len}, 32'd0);
    check_val("reset.good", {31'd0, status_good}, 32'd0);
    check_val("reset.err_fcs", {31'd0, status_err_fcs}, 32'd0);
    check_val("reset.good_count", good_count, 32'd0);
    check_val("reset.bad_count", bad_count, 32'd0);
    rst_n = 1'b1;
    repeat (4) step(1'b0, 1'b0, 8'h00);

    make_frame(7, 8'hD5, 64, 1'b0);   send_frame(1'b0, 12, -1, 1'b0, "gmii64");
    make_frame(7, 8'hD5, 64, 1'b1);   send_frame(1'b0, 12, -1, 1'b0, "fcs_flip");
    make_frame(7, 8'hD5, 64, 1'b0);   send_frame(1'b1, 16, -1, 1'b0, "mii64");
    make_frame(7, 8'hD5, 64, 1'b0);   send_frame(1'b1, 12, -1, 1'b1, "mii_trunc");

    len_tab = '{63, 64, 1518, 1519};
    foreach (len_tab[i]) begin
      make_frame(7, 8'hD5, len_tab[i], 1'b0);
      send_frame(1'b0, 12, -1, 1'b0, $sformatf("len%0d", len_tab[i]));
    end

    make_frame(7, 8'hD5, 64, 1'b0);   send_frame(1'b0, 12, -1, 1'b0, "ifg_a");
    make_frame(7, 8'hD5, 64, 1'b0);   send_frame(1'b0, 11, -1, 1'b0, "ifg11");
    make_frame(7, 8'hD5, 64, 1'b0);   send_frame(1'b0, 12, -1, 1'b0, "ifg12_a");
    make_frame(7, 8'hD5, 64, 1'b0);   send_frame(1'b0, 12, -1, 1'b0, "ifg12_b");
    make_frame(7, 8'hD5, 100, 1'b0);  send_frame(1'b0, 12, 40, 1'b0, "tx_er");
    make_frame(7, 8'hD5, 64, 1'b0);   send_frame(1'b0, 1, -1, 1'b0, "back2back");

    make_frame(8, 8'hD5, 64, 1'b0);   send_frame(1'b0, 12, -1, 1'b0, "pre_8x55");
    make_frame(0, 8'hD5, 64, 1'b0);   send_frame(1'b0, 12, -1, 1'b0, "pre_sfd_first");
    make_frame(7, 8'hD5, 64, 1'b0);
    frm[2] = 8'h57;                   send_frame(1'b0, 12, -1, 1'b0, "pre_57");

    // Reset mid-frame: no status, counters cleared, remainder of that frame ignored.
    make_frame(7, 8'hD5, 100, 1'b0);
    mii_select = 1'b0; cur_mii = 1'b0;
    repeat (11) step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, frm[i]);
    rst_n = 1'b0;
    #1;
    check_val("midrst.valid", {31'd0, status_valid}, 32'd0);
    check_val("midrst.good_count", good_count, 32'd0);
    check_val("midrst.bad_count", bad_count, 32'd0);
    for (int i = 40; i < frm.size(); i++) begin
      if (i == 43) rst_n = 1'b1;
      step(1'b1, 1'b0, frm[i]);
    end
    repeat (20) step(1'b0, 1'b0, 8'($urandom));
    check_val("midrst.pulses", 32'(pulse_cnt), 32'(exp_frames));
    exp_good = 0; exp_bad = 0; first_frame = 1'b1;
    make_frame(7, 8'hD5, 64, 1'b0);   send_frame(1'b0, 12, -1, 1'b0, "post_reset");

    for (int f = 0; f < 30; f++) begin
      mii = 1'($urandom);
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1500, 1530)) : int'($urandom_range(40, 160));
      n55 = $urandom_range(1, 7);
      sfd = 8'hD5;
      pv  = $urandom_range(0, 9);
      if (pv == 0) n55 = 8;
      else if (pv == 1) sfd = 8'($urandom);
      else if (pv == 2) n55 = 0;
      flip = ($urandom_range(0, 5) == 0);
      make_frame(n55, sfd, len, flip);
      if ($urandom_range(0, 7) == 0) er_idx = $urandom_range(0, frm.size() - 1);
      else er_idx = -1;
      trunc = mii && ($urandom_range(0, 7) == 0);
      send_frame(mii, $urandom_range(1, 20), er_idx, trunc, $sformatf("rand%0d", f));
    end

    repeat (10) step(1'b0, 1'b0, 8'h00);
    check_val("total_pulses", 32'(pulse_cnt), 32'(exp_frames));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
